// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the 32-bit adder BIST controller.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED_SUB  = 32'h0000_0001;

  // Corner vectors: full carry ripple, max+max, all zero.
  localparam vec_t CORNER0 = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001};
  localparam vec_t CORNER1 = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF};
  localparam vec_t CORNER2 = '{a: 32'h0000_0000, b: 32'h0000_0000};

  function automatic logic [31:0] nonzero_seed(input logic [31:0] v);
    return (v == 32'h0) ? SEED_SUB : v;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit right-shifting Galois LFSR with synchronous load and advance enable.
module lfsr32
  import adder_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        en,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)
      q <= SEED_SUB;
    else if (load)
      q <= load_val;
    else if (en)
      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 32'h0);
  end

endmodule

// File: rtl/adder_bist_32u.sv
// BIST controller: drives corner + LFSR vectors into a pipelined adder and
// checks the returned sum/carry against a delayed expected-value pipeline.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | one vector issued per cycle
// DRAIN | LAT+1 cycles letting in-flight compares finish
// DONE  | results held until the next accepted start
module adder_bist_32u
  import adder_bist_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LAT   = 2,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNTW-1:0]  num_vectors,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNTW-1:0]  err_count,
  output logic [CNTW-1:0]  first_fail_idx
);

  state_t          state, state_nxt;
  logic [CNTW-1:0] nv_q, vec_idx, issue_idx, drain_cnt;
  logic            accept, issue, lfsr_en;
  logic [31:0]     lfsr_a_q, lfsr_b_q;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]  exp_sum;

  logic [WIDTH:0]  exp_q [LAT+1];
  logic [CNTW-1:0] idx_q [LAT+1];
  logic [LAT:0]    vld_q;
  logic            mismatch;

  assign accept = start && (state == IDLE || state == DONE);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    issue_idx = vec_idx + CNTW'(1);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (num_vectors == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            issue     = 1'b1;
            issue_idx = '0;
          end
        end
      end
      RUN: begin
        if (vec_idx == nv_q - CNTW'(1)) state_nxt = DRAIN;
        else                            issue = 1'b1;
      end
      DRAIN: begin
        if (drain_cnt == '0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_sel   = lfsr_a_q[WIDTH-1:0];
    b_sel   = lfsr_b_q[WIDTH-1:0];
    lfsr_en = 1'b0;
    if (issue_idx == CNTW'(0)) begin
      a_sel = CORNER0.a[WIDTH-1:0];
      b_sel = CORNER0.b[WIDTH-1:0];
    end else if (issue_idx == CNTW'(1)) begin
      a_sel = CORNER1.a[WIDTH-1:0];
      b_sel = CORNER1.b[WIDTH-1:0];
    end else if (issue_idx == CNTW'(2)) begin
      a_sel = CORNER2.a[WIDTH-1:0];
      b_sel = CORNER2.b[WIDTH-1:0];
    end else begin
      lfsr_en = issue;
    end
    exp_sum = {1'b0, a_sel} + {1'b0, b_sel};
  end

  lfsr32 u_lfsr_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (nonzero_seed(32'(seed))),
    .en       (lfsr_en),
    .q        (lfsr_a_q)
  );

  lfsr32 u_lfsr_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (nonzero_seed(32'(~seed))),
    .en       (lfsr_en),
    .q        (lfsr_b_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      nv_q      <= '0;
      vec_idx   <= '0;
      drain_cnt <= '0;
      dut_a     <= '0;
      dut_b     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) nv_q <= num_vectors;
      if (issue)  vec_idx <= issue_idx;
      if (state == RUN && state_nxt == DRAIN)
        drain_cnt <= CNTW'(LAT);
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - CNTW'(1);
      dut_a <= issue ? a_sel : '0;
      dut_b <= issue ? b_sel : '0;
    end
  end

  // Only the valid bits need reset; data stages are qualified by them.
  always_ff @(posedge clk) begin
    if (!rst_n)
      vld_q <= '0;
    else
      vld_q <= {vld_q[LAT-1:0], issue};
  end

  always_ff @(posedge clk) begin
    exp_q[0] <= exp_sum;
    idx_q[0] <= issue_idx;
    for (int i = 1; i <= LAT; i++) begin
      exp_q[i] <= exp_q[i-1];
      idx_q[i] <= idx_q[i-1];
    end
  end

  assign mismatch = vld_q[LAT] && ({dut_cout, dut_sum} != exp_q[LAT]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count      <= '0;
      first_fail_idx <= '1;
    end else if (accept) begin
      err_count      <= '0;
      first_fail_idx <= '1;
    end else if (mismatch) begin
      if (err_count != '1)      err_count      <= err_count + CNTW'(1);
      if (first_fail_idx == '1) first_fail_idx <= idx_q[LAT];
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_adder_bist_32u.sv
// Directed bench for adder_bist_32u with a registered-adder model and fault modes.
module tb_adder_bist_32u;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vectors;
  logic [31:0] seed;
  logic [31:0] dut_a, dut_b, dut_sum;
  logic        dut_cout;
  logic        busy, done, pass;
  logic [15:0] err_count, first_fail_idx;

  logic        flip5 = 1'b0;
  logic        cout0 = 1'b0;
  logic [31:0] a_r = '0, b_r = '0;
  int          cyc = 0, i_r = 0;
  logic [32:0] s_raw;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_bist_32u #(.WIDTH(32), .LAT(2), .CNTW(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_vectors    (num_vectors),
    .seed           (seed),
    .dut_a          (dut_a),
    .dut_b          (dut_b),
    .dut_sum        (dut_sum),
    .dut_cout       (dut_cout),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_idx (first_fail_idx)
  );

  // Adder under test: input register then output register (LAT = 2).
  assign s_raw = {1'b0, a_r} + {1'b0, b_r};
  always @(posedge clk) begin
    a_r      <= dut_a;
    b_r      <= dut_b;
    i_r      <= cyc;
    cyc      <= start ? 0 : cyc + 1;
    dut_sum  <= s_raw[31:0] ^ {31'b0, (flip5 && i_r == 5)};
    dut_cout <= s_raw[32] & ~cout0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [31:0] sd, input logic [15:0] nv, input int poke_at,
                     output int busy_cyc, output int k,
                     output logic [31:0] a3, output logic [31:0] b3,
                     output logic [31:0] a4, output logic [31:0] b4);
    @(negedge clk);
    seed = sd; num_vectors = nv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0; k = 0;
    a3 = '0; b3 = '0; a4 = '0; b4 = '0;
    while (!done && k < 5000) begin
      if (busy) busy_cyc++;
      if (k == 3) begin a3 = dut_a; b3 = dut_b; end
      if (k == 4) begin a4 = dut_a; b4 = dut_b; end
      start = (k == poke_at);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (!done) check("run_timeout", 0, 1);
  endtask

  int          bc, kk;
  logic [31:0] a3, b3, a4, b4;

  initial begin
    rst_n = 1'b0; start = 1'b0; num_vectors = '0; seed = '0;
    repeat (3) @(negedge clk);
    check("rst_dut_a", dut_a, 0);
    check("rst_dut_b", dut_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_ffi", first_fail_idx, 16'hFFFF);
    rst_n = 1'b1;

    // Golden run, seed=1, 1000 vectors; also spot-check corner and LFSR operands.
    run(32'h1, 16'd1000, -1, bc, kk, a3, b3, a4, b4);
    check("gold_busy_cycles", bc, 1003);
    check("gold_done", done, 1);
    check("gold_pass", pass, 1);
    check("gold_err", err_count, 0);
    check("gold_ffi", first_fail_idx, 16'hFFFF);
    check("gold_a3", a3, 32'h0000_0001);
    check("gold_b3", b3, 32'hFFFF_FFFE);
    check("gold_a4", a4, 32'h8020_0003);
    check("gold_b4", b4, 32'h7FFF_FFFF);
    check("done_hold_dut_a", dut_a, 0);

    // Single bit flip on vector 5.
    flip5 = 1'b1;
    run(32'h1, 16'd50, -1, bc, kk, a3, b3, a4, b4);
    flip5 = 1'b0;
    check("flip_err", err_count, 1);
    check("flip_ffi", first_fail_idx, 5);
    check("flip_pass", pass, 0);

    // Carry-out stuck at 0 over the three corner vectors.
    cout0 = 1'b1;
    run(32'h1, 16'd3, -1, bc, kk, a3, b3, a4, b4);
    cout0 = 1'b0;
    check("cout0_err", err_count, 2);
    check("cout0_ffi", first_fail_idx, 0);
    check("cout0_pass", pass, 0);

    // Zero-length run.
    run(32'h1, 16'd0, -1, bc, kk, a3, b3, a4, b4);
    check("nv0_latency", kk, 0);
    check("nv0_done", done, 1);
    check("nv0_pass", pass, 1);
    check("nv0_busy", bc, 0);

    // Start pulsed mid-run is ignored.
    run(32'h1, 16'd20, 5, bc, kk, a3, b3, a4, b4);
    check("poke_busy_cycles", bc, 23);
    check("poke_pass", pass, 1);
    check("poke_err", err_count, 0);

    // Zero seed substitutes 1 for LFSR A.
    run(32'h0, 16'd10, -1, bc, kk, a3, b3, a4, b4);
    check("seed0_a3", a3, 32'h0000_0001);
    check("seed0_b3", b3, 32'hFFFF_FFFF);
    check("seed0_pass", pass, 1);

    // Reset 10 cycles into a 100-vector run with faulty carry in flight.
    cout0 = 1'b1;
    @(negedge clk);
    seed = 32'h1; num_vectors = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_dut_a", dut_a, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err_count, 0);
    check("abort_ffi", first_fail_idx, 16'hFFFF);
    repeat (4) @(negedge clk);
    check("abort_no_stale_cmp", err_count, 0);
    cout0 = 1'b0;
    run(32'h1, 16'd100, -1, bc, kk, a3, b3, a4, b4);
    check("abort_fresh_pass", pass, 1);
    check("abort_fresh_cycles", bc, 103);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
